// File: rtl/conv_encoder_tbz.sv
`default_nettype none
// ============================================================================
// conv_encoder_tbz : rate-1/N convolutional encoder, tail-biting or zero-tail,
//                    N coded streams packed LSB-first into bytes.  Rev 1.0
// ============================================================================
module conv_encoder_tbz #(
  parameter int              K     = 7,
  parameter int              N     = 3,
  parameter logic [N*K-1:0]  GEN   = {7'o165, 7'o171, 7'o133},
  parameter int              LEN_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_zt,
  input  logic [K-2:0]     cfg_tail,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [8*N-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int FW = $clog2(K);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [7:0]       hold_data;
  logic             hold_valid;
  logic [2:0]       bit_idx;
  logic [LEN_W-1:0] bytes_left;
  logic             zt;
  logic [FW-1:0]    flush_cnt;
  logic [K-2:0]     sr;            // sr[j] holds c_{j+1}
  logic [8*N-1:0]   pack, pack_nxt;
  logic [3:0]       pack_cnt, pack_cnt_nxt;

  logic can_accept, pack_full, pack_ok, consume, enc_en, cur_bit, move;
  logic launch, accept, last_run_bit, last_flush_bit, final_hs;
  logic [2:0] pos;

  assign can_accept     = !out_valid || out_ready;
  assign pack_full      = (pack_cnt == 4'd8);
  assign pack_ok        = !pack_full || can_accept;
  assign consume        = (state == S_RUN) && hold_valid && pack_ok;
  assign enc_en         = consume || ((state == S_FLUSH) && pack_ok);
  assign cur_bit        = (state == S_RUN) ? hold_data[bit_idx] : 1'b0;
  assign move           = can_accept && (pack_full || ((state == S_DRAIN) && (pack_cnt != 4'd0)));
  assign launch         = (state == S_IDLE) && start && (cfg_len != '0);
  assign accept         = in_valid && in_ready;
  assign last_run_bit   = consume && (bit_idx == 3'd7) && (bytes_left == '0);
  assign last_flush_bit = (state == S_FLUSH) && enc_en && (flush_cnt == FW'(K - 2));
  assign final_hs       = out_valid && out_ready && out_last;

  // A pack moving out this cycle frees bit 0 for the bit being encoded now
  assign pos          = move ? 3'd0 : pack_cnt[2:0];
  assign pack_cnt_nxt = (move ? 4'd0 : pack_cnt) + {3'd0, enc_en};

  for (genvar s = 0; s < N; s++) begin : g_stream
    logic [K-1:0] taps;
    logic         coded;
    logic [7:0]   byte_cur, byte_nxt;

    for (genvar i = 0; i < K; i++) begin : g_tap
      assign taps[i] = GEN[s*K + K-1-i];
    end

    assign coded    = ^({sr, cur_bit} & taps);
    assign byte_cur = move ? 8'd0 : pack[8*s +: 8];

    always_comb begin
      byte_nxt = byte_cur;
      if (enc_en) byte_nxt[pos] = coded;
    end

    assign pack_nxt[8*s +: 8] = byte_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (launch)         state_nxt = S_RUN;
      S_RUN:   if (last_run_bit)   state_nxt = zt ? S_FLUSH : S_DRAIN;
      S_FLUSH: if (last_flush_bit) state_nxt = S_DRAIN;
      S_DRAIN: if (final_hs)       state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    in_ready = (state == S_RUN) && (!hold_valid || (consume && (bit_idx == 3'd7)))
               && (bytes_left != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      bit_idx    <= '0;
      bytes_left <= '0;
      zt         <= 1'b0;
      flush_cnt  <= '0;
      sr         <= '0;
      pack       <= '0;
      pack_cnt   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done     <= final_hs;
      pack     <= pack_nxt;
      pack_cnt <= pack_cnt_nxt;

      if (launch) begin
        bytes_left <= cfg_len;
        zt         <= cfg_zt;
        sr         <= cfg_zt ? '0 : cfg_tail;
        flush_cnt  <= '0;
        hold_valid <= 1'b0;
        bit_idx    <= '0;
      end else begin
        if (enc_en) sr <= {sr[K-3:0], cur_bit};
        if ((state == S_FLUSH) && enc_en) flush_cnt <= flush_cnt + FW'(1);

        if (accept) begin
          hold_data  <= in_data;
          hold_valid <= 1'b1;
          bit_idx    <= '0;
          bytes_left <= bytes_left - LEN_W'(1);
        end else if (consume) begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) hold_valid <= 1'b0;
        end
      end

      if (move) begin
        out_data  <= pack;
        out_valid <= 1'b1;
        out_last  <= (state == S_DRAIN);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
